// File: rtl/clk_div_checker_pkg.sv
// Shared definitions for the divided-clock checker.
// FSM state encoding and divide-by-4 default phase lengths.
package clk_div_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SYNC      = 2'd1,
        ST_MEAS_HIGH = 2'd2,
        ST_MEAS_LOW  = 2'd3
    } state_t;

    localparam int unsigned DEF_EXP_HIGH = 2;
    localparam int unsigned DEF_EXP_LOW  = 2;

endpackage

// File: rtl/clk_div_checker_edge_detect.sv
// Edge detector for a clk-synchronous divided clock.
// Combinational rise/fall plus gated, registered one-cycle pulses.
module clk_div_checker_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_div,
    input  logic i_active,
    output logic o_rise,
    output logic o_fall,
    output logic o_rise_pulse,
    output logic o_fall_pulse
);

    logic r_div_d;
    logic r_rise_pulse;
    logic r_fall_pulse;

    // Delay the input by one cycle and register gated edge pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_d      <= 1'b0;
            r_rise_pulse <= 1'b0;
            r_fall_pulse <= 1'b0;
        end else begin
            r_div_d      <= i_div;
            r_rise_pulse <= o_rise & i_active;
            r_fall_pulse <= o_fall & i_active;
        end
    end

    assign o_rise       = i_div & ~r_div_d;
    assign o_fall       = ~i_div & r_div_d;
    assign o_rise_pulse = r_rise_pulse;
    assign o_fall_pulse = r_fall_pulse;

endmodule

// File: rtl/clk_div_checker.sv
// Divided-clock monitor: measures high/low phase lengths,
// flags mismatches and timeouts, counts errors, reports lock.
module clk_div_checker
    import clk_div_checker_pkg::*;
#(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned EXP_HIGH = DEF_EXP_HIGH,
    parameter int unsigned EXP_LOW  = DEF_EXP_LOW,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] low_len,
    output logic             meas_valid,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             locked
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] EXP_H_C = CNT_W'(EXP_HIGH);
    localparam logic [CNT_W-1:0] EXP_L_C = CNT_W'(EXP_LOW);
    localparam logic [3:0]       LOCK_C  = 4'(LOCK_CNT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_run_cnt;
    logic [CNT_W-1:0] w_run_nxt;
    logic [CNT_W-1:0] r_high_len;
    logic [CNT_W-1:0] r_low_len;
    logic [ERR_W-1:0] r_err_cnt;
    logic [3:0]       r_good_cnt;
    logic             r_locked;
    logic             r_meas_valid;
    logic             r_err;
    logic             r_period_bad;

    logic w_rise;
    logic w_fall;
    logic w_active;
    logic w_hi_upd;
    logic w_lo_upd;
    logic w_tmo;
    logic w_sync_rise;
    logic w_hi_mis;
    logic w_lo_mis;
    logic w_err;

    assign w_active = (r_state != ST_IDLE);

    clk_div_checker_edge_detect u_edge (
        .clk          (clk),
        .rst          (rst),
        .i_div        (div_in),
        .i_active     (w_active),
        .o_rise       (w_rise),
        .o_fall       (w_fall),
        .o_rise_pulse (rise_pulse),
        .o_fall_pulse (fall_pulse)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, run counter and per-cycle measurement events
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run_cnt;
        w_hi_upd    = 1'b0;
        w_lo_upd    = 1'b0;
        w_tmo       = 1'b0;
        w_sync_rise = 1'b0;
        if (!en) begin
            w_state_nxt = ST_IDLE;
            w_run_nxt   = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_SYNC;
                    w_run_nxt   = '0;
                end
                ST_SYNC: begin
                    if (w_rise) begin
                        w_sync_rise = 1'b1;
                        w_state_nxt = ST_MEAS_HIGH;
                        w_run_nxt   = CNT_W'(1);
                    end
                end
                ST_MEAS_HIGH: begin
                    if (w_fall) begin
                        w_hi_upd    = 1'b1;
                        w_state_nxt = ST_MEAS_LOW;
                        w_run_nxt   = CNT_W'(1);
                    end else if (r_run_cnt == CNT_MAX) begin
                        w_tmo       = 1'b1;
                        w_state_nxt = ST_SYNC;
                        w_run_nxt   = '0;
                    end else begin
                        w_run_nxt = r_run_cnt + CNT_W'(1);
                    end
                end
                ST_MEAS_LOW: begin
                    if (w_rise) begin
                        w_lo_upd    = 1'b1;
                        w_state_nxt = ST_MEAS_HIGH;
                        w_run_nxt   = CNT_W'(1);
                    end else if (r_run_cnt == CNT_MAX) begin
                        w_tmo       = 1'b1;
                        w_state_nxt = ST_SYNC;
                        w_run_nxt   = '0;
                    end else begin
                        w_run_nxt = r_run_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_run_nxt   = '0;
                end
            endcase
        end
    end

    assign w_hi_mis = w_hi_upd && (r_run_cnt != EXP_H_C);
    assign w_lo_mis = w_lo_upd && (r_run_cnt != EXP_L_C);
    assign w_err    = w_hi_mis | w_lo_mis | w_tmo;

    // Lengths, error bookkeeping and lock tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run_cnt    <= '0;
            r_high_len   <= '0;
            r_low_len    <= '0;
            r_err_cnt    <= '0;
            r_good_cnt   <= '0;
            r_locked     <= 1'b0;
            r_meas_valid <= 1'b0;
            r_err        <= 1'b0;
            r_period_bad <= 1'b0;
        end else begin
            r_run_cnt    <= w_run_nxt;
            r_meas_valid <= w_lo_upd;
            r_err        <= w_err;
            if (w_hi_upd) begin
                r_high_len <= r_run_cnt;
            end
            if (w_lo_upd) begin
                r_low_len <= r_run_cnt;
            end
            if (w_err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
            if (w_hi_mis) begin
                r_period_bad <= 1'b1;
            end else if (w_lo_upd || w_sync_rise) begin
                r_period_bad <= 1'b0;
            end
            if (!en || w_err) begin
                r_good_cnt <= '0;
                r_locked   <= 1'b0;
            end else if (w_lo_upd && !r_period_bad) begin
                if (r_good_cnt != LOCK_C) begin
                    r_good_cnt <= r_good_cnt + 4'd1;
                end
                if (r_good_cnt >= LOCK_C - 4'd1) begin
                    r_locked <= 1'b1;
                end
            end
        end
    end

    assign high_len   = r_high_len;
    assign low_len    = r_low_len;
    assign meas_valid = r_meas_valid;
    assign err        = r_err;
    assign err_cnt    = r_err_cnt;
    assign locked     = r_locked;

endmodule

// File: tb/tb_clk_div_checker.sv
// Directed testbench for clk_div_checker.
// Linear stimulus with immediate assertions at each check.
module tb_clk_div_checker;

    logic       clk;
    logic       rst;
    logic       en;
    logic       div_in;
    logic       rise_pulse;
    logic       fall_pulse;
    logic [7:0] high_len;
    logic [7:0] low_len;
    logic       meas_valid;
    logic       err;
    logic [7:0] err_cnt;
    logic       locked;

    int n_tests = 0;
    int n_fail  = 0;
    int n_mv    = 0;
    int n_err   = 0;
    int base;

    clk_div_checker #(
        .CNT_W    (8),
        .EXP_HIGH (2),
        .EXP_LOW  (2),
        .LOCK_CNT (4),
        .ERR_W    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .div_in     (div_in),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .high_len   (high_len),
        .low_len    (low_len),
        .meas_valid (meas_valid),
        .err        (err),
        .err_cnt    (err_cnt),
        .locked     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count output pulses away from the active edge
    always @(negedge clk) begin
        if (meas_valid === 1'b1) n_mv++;
        if (err === 1'b1) n_err++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v);
        div_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic period(input int h, input int l);
        for (int i = 0; i < h; i++) drive(1'b1);
        for (int i = 0; i < l; i++) drive(1'b0);
    endtask

    initial begin
        rst    = 1'b0;
        en     = 1'b0;
        div_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {4'd0, rise_pulse, fall_pulse, meas_valid,
              err, locked, high_len, low_len, err_cnt}, 32'd0);

        // clk/4 lock-in
        rst = 1'b1;
        en  = 1'b1;
        drive(1'b0);
        drive(1'b0);
        repeat (4) period(2, 2);
        check("lock_n_mv3", n_mv, 3);
        check("lock_not_yet", locked, 0);
        drive(1'b1);
        check("mv_pulse", meas_valid, 1);
        check("rise_pulse", rise_pulse, 1);
        check("locked_4th", locked, 1);
        drive(1'b1);
        check("mv_one_cycle", meas_valid, 0);
        check("rise_one_cycle", rise_pulse, 0);
        drive(1'b0);
        check("fall_pulse", fall_pulse, 1);
        check("high_len_2", high_len, 2);
        check("low_len_2", low_len, 2);
        drive(1'b0);
        check("n_mv_4", n_mv, 4);
        check("err_cnt_0", err_cnt, 0);

        // one 3-cycle high phase
        repeat (3) drive(1'b1);
        drive(1'b0);
        check("hi_mis_err", err, 1);
        check("hi_mis_len", high_len, 3);
        check("hi_mis_cnt", err_cnt, 1);
        check("hi_mis_unlock", locked, 0);
        drive(1'b0);
        check("err_one_cycle", err, 0);
        repeat (4) period(2, 2);
        check("relock_not_yet", locked, 0);
        period(2, 2);
        check("relock", locked, 1);
        check("n_mv_10", n_mv, 10);

        // stuck high -> timeout
        drive(1'b1);
        repeat (254) drive(1'b1);
        check("tmo_not_yet", err, 0);
        check("tmo_still_lock", locked, 1);
        drive(1'b1);
        check("tmo_err", err, 1);
        check("tmo_unlock", locked, 0);
        check("tmo_cnt", err_cnt, 2);
        repeat (44) drive(1'b1);
        check("tmo_no_mv", n_mv, 11);
        check("tmo_err_once", n_err, 2);
        drive(1'b0);
        drive(1'b0);
        check("tmo_high_len", high_len, 2);
        repeat (4) period(2, 2);
        check("tmo_relock_not_yet", locked, 0);
        period(2, 2);
        check("tmo_relock", locked, 1);
        check("n_mv_15", n_mv, 15);

        // enable drop mid high phase
        drive(1'b1);
        check("en_pre_lock", locked, 1);
        en = 1'b0;
        drive(1'b1);
        check("en_off_unlock", locked, 0);
        drive(1'b1);
        drive(1'b0);
        check("idle_no_fall", fall_pulse, 0);
        check("idle_high_len", high_len, 2);
        drive(1'b0);
        en = 1'b1;
        drive(1'b1);
        check("idle_no_rise", rise_pulse, 0);
        drive(1'b1);
        drive(1'b0);
        check("sync_fall_pulse", fall_pulse, 1);
        check("sync_high_len", high_len, 2);
        check("sync_err_cnt", err_cnt, 2);
        drive(1'b0);
        check("sync_n_mv", n_mv, 16);
        repeat (5) period(2, 2);
        check("en_relock", locked, 1);
        check("n_mv_20", n_mv, 20);

        // asynchronous reset between edges
        period(2, 2);
        div_in = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_outs", {4'd0, rise_pulse, fall_pulse, meas_valid,
              err, locked, high_len, low_len, err_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b0);
        drive(1'b0);
        period(2, 2);
        check("rst_no_early_mv", n_mv, 21);
        drive(1'b1);
        check("rst_first_mv", meas_valid, 1);
        check("rst_high_len", high_len, 2);
        check("rst_low_len", low_len, 2);
        drive(1'b1);
        drive(1'b0);
        drive(1'b0);

        // high and low mismatch in one period
        base = n_err;
        period(3, 3);
        drive(1'b1);
        check("lo_mis_err", err, 1);
        check("lo_mis_mv", meas_valid, 1);
        check("lo_mis_len", low_len, 3);
        check("lo_mis_cnt", err_cnt, 2);
        check("lo_mis_lock", locked, 0);
        drive(1'b1);
        drive(1'b0);
        drive(1'b0);
        check("two_pulses", n_err - base, 2);

        // error counter saturation
        base = n_err;
        repeat (252) period(3, 2);
        check("sat_254", err_cnt, 254);
        period(3, 2);
        check("sat_255", err_cnt, 255);
        repeat (47) period(3, 2);
        check("sat_hold", err_cnt, 255);
        check("sat_pulses", n_err - base, 300);
        check("sat_unlock", locked, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
